// File: rtl/ascii_num_parser.sv
// ASCII number tokeniser: turns a byte stream into unsigned integer tokens
// with eol/blank/overflow flags and queues them in a small FIFO.
module ascii_num_parser #(
    parameter int WIDTH      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic [WIDTH-1:0] num_out,
    output logic             num_eol,
    output logic             num_blank,
    output logic             num_ovf,
    output logic             num_valid,
    input  logic             num_ready,
    output logic             dropped
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic {EMPTY, IN_NUM} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] val;
        logic             eol;
        logic             blank;
        logic             ovf;
    } tok_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic             ovf, ovf_nx;
    logic [3:0]       digit;
    logic [WIDTH+3:0] prod;
    logic             push;
    tok_t             push_tok;

    tok_t             mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, pop, do_push;
    tok_t             head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            ovf   <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        ovf_nx   = ovf;
        push     = 1'b0;
        push_tok = '{val: acc, eol: 1'b0, blank: 1'b0, ovf: ovf};
        digit    = byte_in[3:0];
        // acc*10 + d with four guard bits so saturation can be detected
        prod     = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{WIDTH{1'b0}}, digit};
        if (byte_valid) begin
            if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
                state_nx = IN_NUM;
                if (state == EMPTY) begin
                    acc_nx = {{(WIDTH-4){1'b0}}, digit};
                    ovf_nx = 1'b0;
                end else if (ovf || prod > {4'b0, {WIDTH{1'b1}}}) begin
                    acc_nx = '1;
                    ovf_nx = 1'b1;
                end else begin
                    acc_nx = prod[WIDTH-1:0];
                end
            end else if (byte_in == 8'h0D) begin
                state_nx = state;
            end else if (byte_in == 8'h0A) begin
                push         = 1'b1;
                push_tok.eol = 1'b1;
                if (state == EMPTY) begin
                    push_tok.val   = '0;
                    push_tok.blank = 1'b1;
                    push_tok.ovf   = 1'b0;
                end
                state_nx = EMPTY;
                acc_nx   = '0;
                ovf_nx   = 1'b0;
            end else if (state == IN_NUM) begin
                push     = 1'b1;
                state_nx = EMPTY;
                acc_nx   = '0;
                ovf_nx   = 1'b0;
            end
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = num_valid & num_ready;
    // a full FIFO still accepts when the head leaves in the same cycle
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            dropped <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_tok;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (push && full && !pop) dropped <= 1'b1;
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign num_out   = head.val;
    assign num_eol   = head.eol;
    assign num_blank = head.blank;
    assign num_ovf   = head.ovf;
    assign num_valid = ~empty;

endmodule

// File: tb/tb_ascii_num_parser.sv
// Directed bench for ascii_num_parser: table of byte strings with expected
// tokens, plus hand sequences for latency, streaming, FIFO-full and reset.
module tb_ascii_num_parser;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        num_ready;

    logic [63:0] num_out;
    logic        num_eol, num_blank, num_ovf, num_valid, dropped;
    logic [7:0]  num_out8;
    logic        num_eol8, num_blank8, num_ovf8, num_valid8, dropped8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ascii_num_parser #(.WIDTH(64), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .num_out(num_out), .num_eol(num_eol), .num_blank(num_blank), .num_ovf(num_ovf),
        .num_valid(num_valid), .num_ready(num_ready), .dropped(dropped)
    );

    ascii_num_parser #(.WIDTH(8), .FIFO_DEPTH(4)) dut8 (
        .clk(clk), .reset_n(reset_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .num_out(num_out8), .num_eol(num_eol8), .num_blank(num_blank8), .num_ovf(num_ovf8),
        .num_valid(num_valid8), .num_ready(num_ready), .dropped(dropped8)
    );

    typedef struct {
        string       in;
        int          n;
        logic [63:0] val [4];
        logic [3:0]  eol;
        logic [3:0]  blank;
        logic [3:0]  ovf;
    } vec_t;

    vec_t tv [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_reset();
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // check head of the selected DUT, then complete one handshake
    task automatic pop_check(input string name, input bit narrow, input logic [63:0] val,
                             input logic eol, input logic blank, input logic ovf);
        if (narrow) begin
            chk({name, ".valid"}, {63'd0, num_valid8}, 64'd1);
            chk({name, ".val"},   {56'd0, num_out8},   val);
            chk({name, ".eol"},   {63'd0, num_eol8},   {63'd0, eol});
            chk({name, ".blank"}, {63'd0, num_blank8}, {63'd0, blank});
            chk({name, ".ovf"},   {63'd0, num_ovf8},   {63'd0, ovf});
        end else begin
            chk({name, ".valid"}, {63'd0, num_valid}, 64'd1);
            chk({name, ".val"},   num_out,            val);
            chk({name, ".eol"},   {63'd0, num_eol},   {63'd0, eol});
            chk({name, ".blank"}, {63'd0, num_blank}, {63'd0, blank});
            chk({name, ".ovf"},   {63'd0, num_ovf},   {63'd0, ovf});
        end
        num_ready = 1'b1;
        @(posedge clk);
        #1 num_ready = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        num_ready  = 1'b0;

        tv[0].in = "123\n";          tv[0].n = 1; tv[0].val[0] = 64'd123;
        tv[0].eol = 4'b0001; tv[0].blank = 4'b0000; tv[0].ovf = 4'b0000;
        tv[1].in = "12,34\015\n";    tv[1].n = 2; tv[1].val[0] = 64'd12; tv[1].val[1] = 64'd34;
        tv[1].eol = 4'b0010; tv[1].blank = 4'b0000; tv[1].ovf = 4'b0000;
        tv[2].in = "\n\n7 \n";       tv[2].n = 4;
        tv[2].val[0] = 64'd0; tv[2].val[1] = 64'd0; tv[2].val[2] = 64'd7; tv[2].val[3] = 64'd0;
        tv[2].eol = 4'b1011; tv[2].blank = 4'b1011; tv[2].ovf = 4'b0000;
        tv[3].in = "a-5x";           tv[3].n = 1; tv[3].val[0] = 64'd5;
        tv[3].eol = 4'b0000; tv[3].blank = 4'b0000; tv[3].ovf = 4'b0000;
        tv[4].in = "18446744073709551615\n"; tv[4].n = 1; tv[4].val[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        tv[4].eol = 4'b0001; tv[4].blank = 4'b0000; tv[4].ovf = 4'b0000;
        tv[5].in = "18446744073709551616999 "; tv[5].n = 1; tv[5].val[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        tv[5].eol = 4'b0000; tv[5].blank = 4'b0000; tv[5].ovf = 4'b0001;
        tv[6].in = "0007\n9\015 ";   tv[6].n = 2; tv[6].val[0] = 64'd7; tv[6].val[1] = 64'd9;
        tv[6].eol = 4'b0001; tv[6].blank = 4'b0000; tv[6].ovf = 4'b0000;

        do_reset();
        chk("rst.num_out",   num_out,            64'd0);
        chk("rst.num_eol",   {63'd0, num_eol},   64'd0);
        chk("rst.num_blank", {63'd0, num_blank}, 64'd0);
        chk("rst.num_ovf",   {63'd0, num_ovf},   64'd0);
        chk("rst.num_valid", {63'd0, num_valid}, 64'd0);
        chk("rst.dropped",   {63'd0, dropped},   64'd0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            send_str(tv[v].in);
            for (int k = 0; k < tv[v].n; k++)
                pop_check($sformatf("vec%0d.tok%0d", v, k), 1'b0, tv[v].val[k],
                          tv[v].eol[k], tv[v].blank[k], tv[v].ovf[k]);
            chk($sformatf("vec%0d.drained", v), {63'd0, num_valid}, 64'd0);
        end

        // latency: token visible one cycle after the terminator strobe
        do_reset();
        send_str("123");
        chk("lat.before", {63'd0, num_valid}, 64'd0);
        byte_in    = 8'h0A;
        byte_valid = 1'b1;
        @(negedge clk);
        chk("lat.strobe_cycle", {63'd0, num_valid}, 64'd0);
        @(posedge clk);
        #1 byte_valid = 1'b0;
        chk("lat.after", {63'd0, num_valid}, 64'd1);
        chk("lat.val", num_out, 64'd123);

        // streaming with consumer always ready
        do_reset();
        num_ready = 1'b1;
        send(",");
        send("1");  send("2");  send(",");
        chk("strm.t0.valid", {63'd0, num_valid}, 64'd1);
        chk("strm.t0.val",   num_out,            64'd12);
        chk("strm.t0.eol",   {63'd0, num_eol},   64'd0);
        send("3");
        chk("strm.popped", {63'd0, num_valid}, 64'd0);
        send("4");  send(8'h0D);
        chk("strm.cr", {63'd0, num_valid}, 64'd0);
        send(8'h0A);
        chk("strm.t1.valid", {63'd0, num_valid}, 64'd1);
        chk("strm.t1.val",   num_out,            64'd34);
        chk("strm.t1.eol",   {63'd0, num_eol},   64'd1);
        send(" ");
        chk("strm.empty", {63'd0, num_valid}, 64'd0);
        num_ready = 1'b0;

        // FIFO full: push+pop same cycle, then a dropped token
        do_reset();
        send_str("1 2 3 4 ");
        chk("full.dropped0", {63'd0, dropped}, 64'd0);
        chk("full.head",     num_out,          64'd1);
        send("9");
        byte_in    = " ";
        byte_valid = 1'b1;
        num_ready  = 1'b1;
        @(posedge clk);
        #1 byte_valid = 1'b0;
        num_ready  = 1'b0;
        chk("full.pushpop.dropped", {63'd0, dropped}, 64'd0);
        chk("full.pushpop.head",    num_out,          64'd2);
        send_str("5 ");
        chk("full.dropped1", {63'd0, dropped}, 64'd1);
        chk("full.held",     num_out,          64'd2);
        pop_check("full.p0", 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
        pop_check("full.p1", 1'b0, 64'd3, 1'b0, 1'b0, 1'b0);
        pop_check("full.p2", 1'b0, 64'd4, 1'b0, 1'b0, 1'b0);
        pop_check("full.p3", 1'b0, 64'd9, 1'b0, 1'b0, 1'b0);
        chk("full.drained", {63'd0, num_valid}, 64'd0);
        chk("full.sticky",  {63'd0, dropped},   64'd1);

        // reset mid-token, asynchronously between edges
        do_reset();
        send_str("8\n45");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst.num_out",   num_out,            64'd0);
        chk("arst.num_eol",   {63'd0, num_eol},   64'd0);
        chk("arst.num_valid", {63'd0, num_valid}, 64'd0);
        chk("arst.dropped",   {63'd0, dropped},   64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        send_str("6\n");
        pop_check("arst.tok", 1'b0, 64'd6, 1'b1, 1'b0, 1'b0);
        chk("arst.single", {63'd0, num_valid}, 64'd0);

        // WIDTH=8 saturation
        do_reset();
        send_str("255\n300\n");
        pop_check("w8.t0", 1'b1, 64'd255, 1'b1, 1'b0, 1'b0);
        pop_check("w8.t1", 1'b1, 64'd255, 1'b1, 1'b0, 1'b1);
        chk("w8.drained", {63'd0, num_valid8}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ascii_num_parser.md
# ascii_num_parser

Downstream consumer of the UART receiver: takes one received byte per strobe and tokenises ASCII puzzle input into unsigned binary integers. Each token carries end-of-line, blank-line and overflow flags. Tokens are buffered in a small FIFO and leave through a valid/ready handshake to the puzzle-solving logic. The input side has no backpressure, so a full FIFO drops tokens and reports it.

## Interface
- WIDTH, 64: bit width of parsed values; must be ≥ 4.
- FIFO_DEPTH, 4: token FIFO entries; power of two, ≥ 2.

- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- byte_in  input  8  received byte; sampled only when byte_valid = 1.
- byte_valid  input  1  one-cycle strobe per received byte; may be high on consecutive cycles.
- num_out  output  WIDTH  value of the token at the FIFO head.
- num_eol  output  1  head token was terminated by 0x0A.
- num_blank  output  1  head token is an empty line (num_out = 0, num_eol = 1).
- num_ovf  output  1  head token saturated during accumulation.
- num_valid  output  1  FIFO non-empty.
- num_ready  input  1  consumer accepts the head token when num_valid & num_ready.
- dropped  output  1  sticky flag: a token was lost to a full FIFO; cleared only by reset.

## Operation
- Parser state machine:
  - EMPTY: no digits are pending.
  - IN_NUM: a number is being accumulated.
  - Registers: accumulator acc[WIDTH-1:0] and token overflow flag ovf.
- Byte classes (evaluated only when byte_valid = 1):
  - Digit, 0x30–0x39, value d:
    - From EMPTY, acc is loaded with d.
    - Otherwise, acc ← acc·10 + d.
    - Next state is IN_NUM.
  - 0x0D (CR): ignored entirely; no change to state, acc or ovf.
  - 0x0A (LF):
    - From IN_NUM, push {acc, eol=1, blank=0, ovf}.
    - From EMPTY, push {0, eol=1, blank=1, ovf=0}.
    - Next state is EMPTY, with acc and ovf cleared.
  - Any other byte (space, ',', '-', letters, …):
    - From IN_NUM, push {acc, eol=0, blank=0, ovf}, then go to EMPTY and clear acc and ovf.
    - From EMPTY, no action.
- Arithmetic:
  - acc·10 is computed as (acc<<3)+(acc<<1) in a WIDTH+4-bit intermediate.
  - If the intermediate exceeds 2^WIDTH−1, acc becomes all-ones and ovf is set.
  - Once ovf is set, acc stays all-ones until the token ends.
  - No signed values; '-' is only a delimiter.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH); full/empty are decoded from the pointer MSB.
  - The head entry drives num_out, num_eol, num_blank and num_ovf combinationally from storage.
  - Push with FIFO not full: accepted.
  - Push with FIFO full and no pop that cycle: token discarded and dropped ← 1.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Pop when empty cannot occur, because pop is gated by num_valid.
  - Pointers wrap modulo 2·FIFO_DEPTH.
- Outputs are undefined-free: when num_valid = 0, the head fields show stale storage, which is zeroed at reset.

## Timing
- Reset (reset_n = 0, asynchronous):
  - State EMPTY; acc = 0; ovf = 0.
  - FIFO empty and storage cleared.
  - Outputs: num_out = 0, num_eol = num_blank = num_ovf = 0, num_valid = 0, dropped = 0.
- Reset mid-token discards partial accumulation. The first byte after release is parsed from EMPTY.
- Latency: a terminating byte sampled at edge N pushes at edge N. num_valid is high in the cycle after edge N if the FIFO was empty. Equivalently, the token is visible one cycle after the terminator strobe.
- Throughput: one byte per cycle sustained. A digit and a terminator may arrive on consecutive cycles.
- num_out and the flags are stable while num_valid = 1 and num_ready = 0. They advance to the next entry on the edge at which the handshake completes.
- Input is never stalled; the block provides no byte-level backpressure.

## Test plan
- Bytes "123\n" → one token: 123, eol=1, blank=0, ovf=0; num_valid rises 1 cycle after the '\n' strobe.
- Bytes "12,34\r\n" with num_ready=1 → token 12 (eol=0), then token 34 (eol=1); CR produces nothing.
- Bytes "\n\n7 \n", byte_valid every cycle → four tokens in order:
  - (0, blank=1, eol=1)
  - (0, blank=1, eol=1)
  - (7, eol=0)
  - (0, blank=1, eol=1)
- WIDTH=8, bytes "255\n300\n" → token 255 with ovf=0, then token 255 with ovf=1.
- FIFO_DEPTH=4, num_ready=0, bytes "1 2 3 4 5 " → values 1–4 held and dropped=1. Then num_ready=1 → 1,2,3,4 popped in order; num_valid falls; dropped stays 1.
- Bytes "45", reset_n pulsed low, then "6\n" → single token 6, eol=1; all outputs read reset values during reset.
